// File: rtl/systolic_feeder_pkg.sv
// Shared state encoding, default widths and row types for the systolic feeder slice.
// feed_len gives the number of skewed feed steps needed to flush a DIM x DIM product.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} feeder_state_e;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  typedef logic signed [DEF_BITS_AB-1:0] ab_elem_t;
  typedef logic signed [DEF_BITS_C-1:0]  c_elem_t;
  typedef ab_elem_t [DEF_DIM-1:0]        ab_row_t;
  typedef c_elem_t  [DEF_DIM-1:0]        c_row_t;

  function automatic int feed_len(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Loader, array and result-stream signals of the feeder. The master view is the feeder;
// the slave view is the loader/array/consumer side. A handshake takes place on res_valid & res_ready.
interface systolic_feeder_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
);
  localparam int RW = $clog2(DIM);

  logic                        ld_en;
  logic                        ld_sel;
  logic [RW-1:0]               ld_idx;
  logic [DIM*BITS_AB-1:0]      ld_data;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        arr_en;
  logic                        arr_WrEn;
  logic [DIM-1:0][BITS_AB-1:0] arr_A;
  logic [DIM-1:0][BITS_AB-1:0] arr_B;
  logic [DIM-1:0][BITS_C-1:0]  arr_Cin;
  logic [RW-1:0]               arr_Crow;
  logic [DIM-1:0][BITS_C-1:0]  arr_Cout;
  logic                        res_valid;
  logic                        res_ready;
  logic [RW-1:0]               res_row;
  logic [DIM-1:0][BITS_C-1:0]  res_data;

  modport master (
    input  ld_en, ld_sel, ld_idx, ld_data, start, arr_Cout, res_ready,
    output busy, done, arr_en, arr_WrEn, arr_A, arr_B, arr_Cin, arr_Crow,
           res_valid, res_row, res_data
  );

  modport slave (
    output ld_en, ld_sel, ld_idx, ld_data, start, arr_Cout, res_ready,
    input  busy, done, arr_en, arr_WrEn, arr_A, arr_B, arr_Cin, arr_Crow,
           res_valid, res_row, res_data
  );

endinterface

// File: rtl/systolic_feeder_skew_buf.sv
// DIM x DIM operand register file that presents the diagonal slice for feed step t.
// Writes land on the clock edge; the slice is combinational from the stored rows and t.
module systolic_skew_buf #(
  parameter int DIM       = 8,
  parameter int BITS      = 8,
  parameter int TW        = 5,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DIM)-1:0]   widx,
  input  logic [DIM-1:0][BITS-1:0] wdata,
  input  logic [TW-1:0]            t,
  output logic [DIM-1:0][BITS-1:0] slice
);

  logic [DIM-1:0][BITS-1:0] mem [DIM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Lane i carries element k where i + k == t; lanes outside the wavefront stay zero.
  always_comb begin
    slice = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (int'(t) == i + k) slice[i] = TRANSPOSE ? mem[k][i] : mem[i][k];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Drives the systolic MAC array: clear accumulators, stream skewed A/B, drain C rows.
// First result row 4*DIM-1 edges after start; a row holds while res_ready is low.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.master bus
);

  localparam int FLEN = feed_len(DIM);
  localparam int RW   = $clog2(DIM);
  localparam int CW   = $clog2(FLEN);

  feeder_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_q, done_nxt;
  logic          idle, a_we, b_we;
  logic          arr_en, arr_wren, res_valid;
  logic [RW-1:0] crow;
  logic [DIM-1:0][BITS_AB-1:0] a_slice, b_slice;

  assign idle = (state == IDLE);
  assign a_we = idle & bus.ld_en & ~bus.ld_sel;
  assign b_we = idle & bus.ld_en & bus.ld_sel;

  systolic_skew_buf #(.DIM(DIM), .BITS(BITS_AB), .TW(CW), .TRANSPOSE(1'b0)) u_abuf (
    .clk(clk), .rst(rst), .we(a_we), .widx(bus.ld_idx), .wdata(bus.ld_data),
    .t(cnt), .slice(a_slice)
  );

  systolic_skew_buf #(.DIM(DIM), .BITS(BITS_AB), .TW(CW), .TRANSPOSE(1'b1)) u_bbuf (
    .clk(clk), .rst(rst), .we(b_we), .widx(bus.ld_idx), .wdata(bus.ld_data),
    .t(cnt), .slice(b_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    arr_en    = 1'b0;
    arr_wren  = 1'b0;
    res_valid = 1'b0;
    crow      = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        arr_wren = 1'b1;
        crow     = cnt[RW-1:0];
        if (cnt == CW'(DIM - 1)) begin
          state_nxt = FEED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FEED: begin
        arr_en = 1'b1;
        if (cnt == CW'(FLEN - 1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        res_valid = 1'b1;
        crow      = cnt[RW-1:0];
        if (bus.res_ready) begin
          if (cnt == CW'(DIM - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand lanes are forced to zero outside FEED so the array sees no stray data.
  assign bus.arr_A     = (state == FEED) ? a_slice : '0;
  assign bus.arr_B     = (state == FEED) ? b_slice : '0;
  assign bus.arr_en    = arr_en;
  assign bus.arr_WrEn  = arr_wren;
  assign bus.arr_Cin   = '0;
  assign bus.arr_Crow  = crow;
  assign bus.res_valid = res_valid;
  assign bus.res_row   = res_valid ? crow : '0;
  assign bus.res_data  = res_valid ? bus.arr_Cout : '0;
  assign bus.busy      = ~idle;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Feeder paired with a behavioural output-stationary systolic array; directed matrix products
// with hand-computed results, latency, backpressure, rerun-without-reload and mid-run reset.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int RW      = $clog2(DIM);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feeder_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) bus ();
  systolic_feeder #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Array: A moves right, B moves down, each PE accumulates in place.
  logic signed [BITS_AB-1:0] a_in [DIM][DIM], b_in [DIM][DIM];
  logic signed [BITS_AB-1:0] a_reg[DIM][DIM], b_reg[DIM][DIM];
  logic signed [BITS_C-1:0]  acc  [DIM][DIM], prod [DIM][DIM];

  always_comb begin
    for (int x = 0; x < DIM; x++) begin
      a_in[x][0] = bus.arr_A[x];
      for (int y = 1; y < DIM; y++) a_in[x][y] = a_reg[x][y-1];
    end
    for (int y = 0; y < DIM; y++) begin
      b_in[0][y] = bus.arr_B[y];
      for (int x = 1; x < DIM; x++) b_in[x][y] = b_reg[x-1][y];
    end
    for (int x = 0; x < DIM; x++)
      for (int y = 0; y < DIM; y++)
        prod[x][y] = BITS_C'(a_in[x][y]) * BITS_C'(b_in[x][y]);
    for (int y = 0; y < DIM; y++) bus.arr_Cout[y] = acc[bus.arr_Crow][y];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int x = 0; x < DIM; x++)
        for (int y = 0; y < DIM; y++) begin
          acc[x][y]   <= '0;
          a_reg[x][y] <= '0;
          b_reg[x][y] <= '0;
        end
    end else begin
      if (bus.arr_en)
        for (int x = 0; x < DIM; x++)
          for (int y = 0; y < DIM; y++) begin
            acc[x][y]   <= acc[x][y] + prod[x][y];
            a_reg[x][y] <= a_in[x][y];
            b_reg[x][y] <= b_in[x][y];
          end
      if (bus.arr_WrEn)
        for (int y = 0; y < DIM; y++) acc[bus.arr_Crow][y] <= bus.arr_Cin[y];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_row(input logic sel, input int idx, input logic [DIM*BITS_AB-1:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_idx  = RW'(idx);
    bus.ld_data = data;
    @(negedge clk);
    bus.ld_en   = 1'b0;
  endtask

  task automatic load_fill(input logic [BITS_AB-1:0] a, input logic [BITS_AB-1:0] b);
    for (int k = 0; k < DIM; k++) begin
      load_row(1'b0, k, {DIM{a}});
      load_row(1'b1, k, {DIM{b}});
    end
  endtask

  task automatic load_ident();
    logic [DIM*BITS_AB-1:0] r;
    for (int k = 0; k < DIM; k++) begin
      r = '0;
      r[k*BITS_AB +: BITS_AB] = 8'd1;
      load_row(1'b0, k, r);
      load_row(1'b1, k, r);
    end
  endtask

  // n counts edges after the start edge; a row seen at n is taken on edge n+1.
  task automatic run(input string nm, input logic [15:0] dg, input logic [15:0] od,
                     input int stall_row, input bit junk);
    int rows, stalls, dones, first, done_at, n;
    logic [15:0] e;
    rows = 0; stalls = 0; dones = 0; first = -1; done_at = -1; n = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (n < 300 && !(done_at >= 0 && n > done_at + 2)) begin
      if (n == 0)  chk({nm, " busy"}, 32'(bus.busy), 32'd1);
      if (n == 3)  chk({nm, " clear_en_wren"}, 32'({bus.arr_en, bus.arr_WrEn}), 32'd1);
      if (n == 12) chk({nm, " feed_en_wren"}, 32'({bus.arr_en, bus.arr_WrEn}), 32'd2);
      if (junk && (n == 4 || n == 14)) begin
        bus.ld_en   = 1'b1;
        bus.ld_sel  = (n == 14);
        bus.ld_idx  = '0;
        bus.ld_data = '1;
      end else begin
        bus.ld_en = 1'b0;
      end
      bus.start = junk && (n == 20);
      if (bus.res_valid && first < 0) begin
        first = n;
        chk({nm, " latency"}, 32'(n + 1), 32'(4 * DIM - 1));
      end
      if (bus.res_valid && rows == stall_row && stalls < 5) begin
        bus.res_ready = 1'b0;
        stalls++;
      end else begin
        bus.res_ready = 1'b1;
      end
      if (bus.res_valid) begin
        chk({nm, " res_row"}, 32'(bus.res_row), 32'(rows));
        for (int j = 0; j < DIM; j++) begin
          e = (rows == j) ? dg : od;
          chk({nm, " res_data"}, 32'(bus.res_data[j]), 32'(e));
        end
        if (bus.res_ready) rows++;
      end
      if (bus.done) begin
        dones++;
        done_at = n;
        chk({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({nm, " done_time"}, 32'(n), 32'(5 * DIM - 2 + stalls));
      end
      n++;
      @(negedge clk);
    end
    bus.ld_en = 1'b0;
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    chk({nm, " rows_delivered"}, 32'(rows), 32'(DIM));
    chk({nm, " done_pulses"}, 32'(dones), 32'd1);
    if (stall_row >= 0) chk({nm, " stall_cycles"}, 32'(stalls), 32'd5);
  endtask

  initial begin
    rst = 1'b1;
    bus.ld_en = 1'b0;
    bus.ld_sel = 1'b0;
    bus.ld_idx = '0;
    bus.ld_data = '0;
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst arr_en_wren", 32'({bus.arr_en, bus.arr_WrEn}), 32'd0);
    chk("rst arr_Crow", 32'(bus.arr_Crow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    load_ident();
    run("t1_ident", 16'd1, 16'd0, -1, 1'b0);
    load_fill(8'd2, 8'd3);
    run("t2_fill", 16'd48, 16'd48, -1, 1'b0);
    load_fill(8'h80, 8'h7f);
    run("t3_wrap", 16'd1024, 16'd1024, -1, 1'b0);
    load_fill(8'd2, 8'd3);
    run("t4_stall", 16'd48, 16'd48, 3, 1'b0);
    run("t5_run1", 16'd48, 16'd48, -1, 1'b1);
    run("t5_run2", 16'd48, 16'd48, -1, 1'b0);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("t6 in_feed", 32'(bus.arr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 busy", 32'(bus.busy), 32'd0);
    chk("t6 res_valid", 32'(bus.res_valid), 32'd0);
    chk("t6 arr_en_wren", 32'({bus.arr_en, bus.arr_WrEn}), 32'd0);
    chk("t6 arr_ab", 32'((|bus.arr_A) | (|bus.arr_B)), 32'd0);
    chk("t6 arr_Crow", 32'(bus.arr_Crow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_fill(8'd2, 8'd3);
    run("t6_after", 16'd48, 16'd48, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
